btb_update_writer: RTL and testbench

Write-side companion of the branch target buffer's LRU next-state logic. It accepts resolved-branch updates from EX, queues them, looks up the addressed set, and picks the target way: a tag hit, else an invalid way, else the LRU victim. It then issues one BTB write per granted cycle and raises `update_index`/`update_lru_write` toward the LRU next-state logic for every installed entry. Sits between the EX-stage branch resolution and the BTB storage arrays, 2-way, `SETS` sets.

---
 rtl/btb_update_writer_if.sv | 54 +++++
 rtl/btb_update_writer.sv | 192 +++++++++++++++++++
 tb/tb_btb_update_writer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_writer_if.sv
// Bundle of the update, lookup and BTB write-port signals of btb_update_writer.
// The slave side is the writer itself; the master side is its environment
// (EX-stage producer, BTB arrays, LRU next-state logic).
interface btb_update_writer_if #(
    parameter int unsigned SETS  = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned TAG_W = 27
);
    // Resolved-branch update handshake from EX
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_index;
    logic [TAG_W-1:0] upd_tag;
    logic [31:0]      upd_target;
    logic             upd_taken;

    // Set probe toward the BTB arrays
    logic [IDX_W-1:0] lookup_index;
    logic             way0_valid;
    logic             way1_valid;
    logic [TAG_W-1:0] way0_tag;
    logic [TAG_W-1:0] way1_tag;
    logic [SETS-1:0]  LRU;

    // BTB write port
    logic             wr_grant;
    logic             btb_wr_en;
    logic [IDX_W-1:0] btb_wr_index;
    logic             btb_wr_way;
    logic [TAG_W-1:0] btb_wr_tag;
    logic [31:0]      btb_wr_target;
    logic             btb_wr_valid;

    // LRU next-state notification and status
    logic [IDX_W-1:0] update_index;
    logic             update_lru_write;
    logic             busy;

    modport master (
        output upd_valid, upd_index, upd_tag, upd_target, upd_taken,
        output way0_valid, way1_valid, way0_tag, way1_tag, LRU, wr_grant,
        input  upd_ready, lookup_index,
        input  btb_wr_en, btb_wr_index, btb_wr_way, btb_wr_tag, btb_wr_target, btb_wr_valid,
        input  update_index, update_lru_write, busy
    );

    modport slave (
        input  upd_valid, upd_index, upd_tag, upd_target, upd_taken,
        input  way0_valid, way1_valid, way0_tag, way1_tag, LRU, wr_grant,
        output upd_ready, lookup_index,
        output btb_wr_en, btb_wr_index, btb_wr_way, btb_wr_tag, btb_wr_target, btb_wr_valid,
        output update_index, update_lru_write, busy
    );
endinterface

// File: rtl/btb_update_writer.sv
// BTB update writer: queues resolved-branch updates, probes the addressed set,
// picks a way (hit, else invalid way, else LRU victim) and issues one BTB write
// per granted cycle, notifying the LRU next-state logic on every install.
module btb_update_writer #(
    parameter int unsigned SETS  = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned TAG_W = 27,
    parameter int unsigned DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    btb_update_writer_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             taken;
    } upd_t;

    typedef enum logic [1:0] {StIdle, StLookup, StWrite} state_e;
    typedef enum logic [1:0] {ActDrop, ActInstall, ActInval} act_e;

    // FIFO state
    upd_t             mem_q [DEPTH];
    upd_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Control and working register
    state_e state_q, state_d;
    upd_t   work_q, work_d;
    logic   way_q, way_d;
    act_e   act_q, act_d;

    logic            push, pop;
    logic            fifo_empty, fifo_full;
    logic            hit0, hit1;
    logic            sel_way;
    act_e            sel_act;
    logic            wr_fire, wr_done, wr_en;
    logic [SETS-1:0] lru_vec;
    upd_t            upd_in;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCnt);
    assign push       = bus.upd_valid && !fifo_full;
    assign lru_vec    = bus.LRU;

    // Incoming update packed into a FIFO entry
    always_comb begin
        upd_in        = '0;
        upd_in.index  = bus.upd_index;
        upd_in.tag    = bus.upd_tag;
        upd_in.target = bus.upd_target;
        upd_in.taken  = bus.upd_taken;
    end

    // Way selection and action for the working entry against the probed set
    always_comb begin
        hit0 = bus.way0_valid && (bus.way0_tag == work_q.tag);
        hit1 = bus.way1_valid && (bus.way1_tag == work_q.tag);

        if (hit0) begin
            sel_way = 1'b0;
        end else if (hit1) begin
            sel_way = 1'b1;
        end else if (!bus.way0_valid) begin
            sel_way = 1'b0;
        end else if (!bus.way1_valid) begin
            sel_way = 1'b1;
        end else begin
            sel_way = lru_vec[work_q.index];
        end

        if (work_q.taken) begin
            sel_act = ActInstall;
        end else if (hit0 || hit1) begin
            sel_act = ActInval;
        end else begin
            sel_act = ActDrop;
        end
    end

    // FSM next state, pop decision and working-register load
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        way_d   = way_q;
        act_d   = act_q;
        pop     = 1'b0;
        wr_fire = 1'b0;
        wr_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                way_d   = sel_way;
                act_d   = sel_act;
                state_d = StWrite;
            end
            StWrite: begin
                // A drop retires in one cycle; a real write waits for the port
                wr_fire = (act_q != ActDrop) && bus.wr_grant;
                wr_done = (act_q == ActDrop) || bus.wr_grant;
                if (wr_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StLookup;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            work_d = mem_q[rd_ptr_q];
        end
    end

    // FIFO pointer, count and storage next state
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = upd_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state, pointers and working register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            work_q   <= '0;
            way_q    <= 1'b0;
            act_q    <= ActDrop;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            work_q   <= work_d;
            way_q    <= way_d;
            act_q    <= act_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Outputs; forced to their reset values while rst is high so no write
    // can leak out of the reset cycle
    always_comb begin
        wr_en                = wr_fire && !rst;
        bus.upd_ready        = rst || !fifo_full;
        bus.busy             = !rst && (!fifo_empty || (state_q != StIdle));
        bus.lookup_index     = (!rst && (state_q == StLookup)) ? work_q.index : '0;
        bus.btb_wr_en        = wr_en;
        bus.btb_wr_index     = wr_en ? work_q.index : '0;
        bus.btb_wr_way       = wr_en ? way_q : 1'b0;
        bus.btb_wr_tag       = wr_en ? work_q.tag : '0;
        bus.btb_wr_target    = wr_en ? work_q.target : '0;
        bus.btb_wr_valid     = wr_en && (act_q == ActInstall);
        bus.update_lru_write = wr_en && (act_q == ActInstall);
        bus.update_index     = wr_en ? work_q.index : '0;
    end

endmodule

// File: tb/tb_btb_update_writer.sv
// Directed bench for btb_update_writer: a sequential model of the BTB set
// contents predicts the ordered list of BTB writes; a compare thread checks
// every cycle against it, and directed steps pin latency, way choice,
// backpressure, throughput and reset behaviour with literal values.
module tb_btb_update_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btb_update_writer_if #(.SETS(8), .IDX_W(3), .TAG_W(27)) bif ();

    btb_update_writer #(.SETS(8), .IDX_W(3), .TAG_W(27), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [2:0]  index;
        logic        way;
        logic [26:0] tag;
        logic [31:0] target;
        logic        valid;
    } wr_t;

    // arr: set contents as the BTB arrays hold them; mdl: contents after all
    // accepted updates, used to predict each write at push time
    logic [1:0]  arr_v [8];
    logic [26:0] arr_t [8][2];
    logic [1:0]  mdl_v [8];
    logic [26:0] mdl_t [8][2];

    wr_t         exp_q[$];
    int          wr_cyc_q[$];
    int          total = 0;
    int          bad   = 0;
    logic        last_way;
    logic [2:0]  last_index;
    logic        last_valid;

    assign bif.way0_valid = arr_v[bif.lookup_index][0];
    assign bif.way1_valid = arr_v[bif.lookup_index][1];
    assign bif.way0_tag   = arr_t[bif.lookup_index][0];
    assign bif.way1_tag   = arr_t[bif.lookup_index][1];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Model of one accepted update: hit, else free way, else LRU victim
    task automatic model_push(input logic [2:0] idx, input logic [26:0] tag,
                              input logic [31:0] tgt, input logic taken);
        logic h0, h1, w;
        wr_t  e;
        h0 = mdl_v[idx][0] && (mdl_t[idx][0] == tag);
        h1 = mdl_v[idx][1] && (mdl_t[idx][1] == tag);
        if (h0)                w = 1'b0;
        else if (h1)           w = 1'b1;
        else if (!mdl_v[idx][0]) w = 1'b0;
        else if (!mdl_v[idx][1]) w = 1'b1;
        else                   w = bif.LRU[idx];
        if (taken || h0 || h1) begin
            e.index  = idx;
            e.way    = w;
            e.tag    = tag;
            e.target = tgt;
            e.valid  = taken;
            exp_q.push_back(e);
            mdl_v[idx][w] = taken;
            if (taken) mdl_t[idx][w] = tag;
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic w, input logic v,
                           input logic [26:0] tag);
        arr_v[idx][w] = v;
        arr_t[idx][w] = tag;
        mdl_v[idx][w] = v;
        mdl_t[idx][w] = tag;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one update from posedge+1; returns at posedge+1 after acceptance
    task automatic push(input logic [2:0] idx, input logic [26:0] tag,
                        input logic [31:0] tgt, input logic taken);
        int waited = 0;
        bif.upd_valid  = 1'b1;
        bif.upd_index  = idx;
        bif.upd_tag    = tag;
        bif.upd_target = tgt;
        bif.upd_taken  = taken;
        forever begin
            @(negedge clk);
            if (bif.upd_ready) break;
            waited++;
            if (waited > 50) begin
                fail_now("push_wait");
                bif.upd_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_push(idx, tag, tgt, taken);
        #1;
        bif.upd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bif.busy) begin
                at = cyc;
                return;
            end
        end
        fail_now("wait_idle");
    endtask

    // Per-cycle comparison of all write-side outputs against the model
    task automatic compare_loop();
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_wr_en", 96'(bif.btb_wr_en), 96'd0);
                chk("rst_ready", 96'(bif.upd_ready), 96'd1);
                chk("rst_busy", 96'(bif.busy), 96'd0);
            end else if (bif.btb_wr_en) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_index", 96'(bif.btb_wr_index), 96'(e.index));
                    chk("wr_way", 96'(bif.btb_wr_way), 96'(e.way));
                    chk("wr_tag", 96'(bif.btb_wr_tag), 96'(e.tag));
                    chk("wr_target", 96'(bif.btb_wr_target), 96'(e.target));
                    chk("wr_valid", 96'(bif.btb_wr_valid), 96'(e.valid));
                    chk("lru_write", 96'(bif.update_lru_write), 96'(e.valid));
                    chk("update_index", 96'(bif.update_index), 96'(e.index));
                    arr_v[e.index][e.way] = e.valid;
                    if (e.valid) arr_t[e.index][e.way] = e.tag;
                    wr_cyc_q.push_back(cyc);
                    last_way   = bif.btb_wr_way;
                    last_index = bif.btb_wr_index;
                    last_valid = bif.btb_wr_valid;
                end
            end else begin
                chk("idle_outs", {bif.btb_wr_index, bif.btb_wr_way, bif.btb_wr_tag,
                                  bif.btb_wr_target, bif.btb_wr_valid,
                                  bif.update_lru_write, bif.update_index}, 96'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_idle;
        int c0;
        bif.upd_valid  = 1'b0;
        bif.upd_index  = '0;
        bif.upd_tag    = '0;
        bif.upd_target = '0;
        bif.upd_taken  = 1'b0;
        bif.LRU        = '0;
        bif.wr_grant   = 1'b1;
        for (int s = 0; s < 8; s++) begin
            arr_v[s] = '0;
            mdl_v[s] = '0;
            for (int w = 0; w < 2; w++) begin
                arr_t[s][w] = '0;
                mdl_t[s][w] = '0;
            end
        end
        fork
            compare_loop();
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_ready", 96'(bif.upd_ready), 96'd1);
        chk("init_busy", 96'(bif.busy), 96'd0);
        chk("init_lookup", 96'(bif.lookup_index), 96'd0);
        chk("init_wr_en", 96'(bif.btb_wr_en), 96'd0);

        // Install into an empty set: write lands in cycle N+3
        sync();
        push(3'd3, 27'h1234, 32'h80, 1'b1);
        @(negedge clk);
        chk("t1_n1_wr_en", 96'(bif.btb_wr_en), 96'd0);
        @(negedge clk);
        chk("t1_n2_lookup", 96'(bif.lookup_index), 96'd3);
        @(negedge clk);
        chk("t1_n3_wr_en", 96'(bif.btb_wr_en), 96'd1);
        chk("t1_n3_index", 96'(bif.btb_wr_index), 96'd3);
        chk("t1_n3_way", 96'(bif.btb_wr_way), 96'd0);
        chk("t1_n3_valid", 96'(bif.btb_wr_valid), 96'd1);
        chk("t1_n3_lru_wr", 96'(bif.update_lru_write), 96'd1);
        chk("t1_n3_upd_idx", 96'(bif.update_index), 96'd3);
        wait_idle(t_idle);

        // Full set 5, no tag match: victim follows LRU[5]
        preload(3'd5, 1'b0, 1'b1, 27'h111);
        preload(3'd5, 1'b1, 1'b1, 27'h222);
        bif.LRU = 8'b0010_0000;
        sync();
        push(3'd5, 27'h333, 32'h500, 1'b1);
        wait_idle(t_idle);
        chk("t2_lru1_way", 96'(last_way), 96'd1);
        chk("t2_lru1_index", 96'(last_index), 96'd5);
        bif.LRU = 8'b0000_0000;
        sync();
        push(3'd5, 27'h444, 32'h504, 1'b1);
        wait_idle(t_idle);
        chk("t2_lru0_way", 96'(last_way), 96'd0);

        // Not-taken hit on way 1 invalidates it
        preload(3'd2, 1'b0, 1'b1, 27'h0AA);
        preload(3'd2, 1'b1, 1'b1, 27'h0BB);
        sync();
        push(3'd2, 27'h0BB, 32'h600, 1'b0);
        repeat (3) @(negedge clk);
        chk("t3_inv_wr_en", 96'(bif.btb_wr_en), 96'd1);
        chk("t3_inv_way", 96'(bif.btb_wr_way), 96'd1);
        chk("t3_inv_valid", 96'(bif.btb_wr_valid), 96'd0);
        chk("t3_inv_lru_wr", 96'(bif.update_lru_write), 96'd0);
        wait_idle(t_idle);

        // Not-taken miss: dropped, FSM idle 3 cycles after the pop
        sync();
        push(3'd2, 27'h0CC, 32'h700, 1'b0);
        @(negedge clk);
        chk("t3_drop_busy_n1", 96'(bif.busy), 96'd1);
        @(negedge clk);
        chk("t3_drop_lookup", 96'(bif.lookup_index), 96'd2);
        @(negedge clk);
        chk("t3_drop_busy_n3", 96'(bif.busy), 96'd1);
        chk("t3_drop_wr_en", 96'(bif.btb_wr_en), 96'd0);
        @(negedge clk);
        chk("t3_drop_busy_n4", 96'(bif.busy), 96'd0);

        // Five back-to-back pushes without grant fill working reg + FIFO
        bif.wr_grant = 1'b0;
        sync();
        c0 = cyc;
        push(3'd0, 27'h1000, 32'h1000, 1'b1);
        push(3'd1, 27'h1001, 32'h1004, 1'b1);
        push(3'd4, 27'h1002, 32'h1008, 1'b1);
        push(3'd6, 27'h1003, 32'h100C, 1'b1);
        push(3'd7, 27'h1004, 32'h1010, 1'b1);
        chk("t4_no_stall", 96'(cyc - c0), 96'd5);
        @(negedge clk);
        chk("t4_ready_full", 96'(bif.upd_ready), 96'd0);
        chk("t4_busy", 96'(bif.busy), 96'd1);
        wr_cyc_q.delete();
        sync();
        bif.wr_grant = 1'b1;
        wait_idle(t_idle);
        chk("t4_writes", 96'(wr_cyc_q.size()), 96'd5);
        if (wr_cyc_q.size() == 5) begin
            for (int i = 1; i < 5; i++) begin
                chk("t4_spacing", 96'(wr_cyc_q[i] - wr_cyc_q[i-1]), 96'd2);
            end
            chk("t4_idle_after", 96'(t_idle - wr_cyc_q[4]), 96'd1);
        end
        chk("t4_model_drained", 96'(exp_q.size()), 96'd0);

        // Reset while stalled in WRITE with two entries queued
        bif.wr_grant = 1'b0;
        sync();
        push(3'd0, 27'h2000, 32'h2000, 1'b1);
        push(3'd1, 27'h2001, 32'h2004, 1'b1);
        push(3'd4, 27'h2002, 32'h2008, 1'b1);
        @(negedge clk);
        chk("t5_busy_pre", 96'(bif.busy), 96'd1);
        sync();
        rst          = 1'b1;
        bif.wr_grant = 1'b1;
        sync();
        rst = 1'b0;
        exp_q.delete();
        mdl_v = arr_v;
        mdl_t = arr_t;
        wr_cyc_q.delete();
        @(negedge clk);
        chk("t5_ready_post", 96'(bif.upd_ready), 96'd1);
        chk("t5_busy_post", 96'(bif.busy), 96'd0);
        repeat (10) @(negedge clk);
        chk("t5_no_write", 96'(wr_cyc_q.size()), 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
